// File: rtl/read_ddr_fifo.sv
// Dual-clock FIFO: 256-bit words written, read back as eight 32-bit slices (LSB slice first).
// Gray-coded pointers cross through 2-flop synchronizers; all flags/levels are registered.
module read_ddr_fifo (
    input  logic         wr_clk,
    input  logic         wr_rst,
    input  logic [255:0] wr_data,
    input  logic         wr_en,
    output logic         wr_full,
    output logic [8:0]   wr_water_level,
    output logic         almost_full,
    input  logic         rd_clk,
    input  logic         rd_rst,
    input  logic         rd_en,
    output logic [31:0]  rd_data,
    output logic         rd_empty,
    output logic [11:0]  rd_water_level,
    output logic         almost_empty
);

    localparam logic [8:0]  WR_FULL_LEVEL   = 9'd256;
    localparam logic [8:0]  WR_ALMOST_FULL  = 9'd252;
    localparam logic [11:0] RD_ALMOST_EMPTY = 12'd4;

    logic [255:0] mem [0:255];

    // ---------------- write domain ----------------
    logic [8:0]  wr_ptr_reg;
    logic [8:0]  wr_ptr_next;
    logic [8:0]  wr_gray_reg;
    logic [8:0]  rd_gray_sync1_reg;
    logic [8:0]  rd_gray_sync2_reg;
    logic [8:0]  rd_word_ptr_sync;
    logic [8:0]  wr_level_reg;
    logic [8:0]  wr_level_next;
    logic        wr_full_reg;
    logic        almost_full_reg;
    logic        wr_accept;

    // ---------------- read domain -----------------
    logic [11:0] rd_ptr_reg;
    logic [11:0] rd_ptr_next;
    logic [11:0] rd_gray_reg;
    logic [8:0]  wr_gray_sync1_reg;
    logic [8:0]  wr_gray_sync2_reg;
    logic [8:0]  wr_ptr_sync;
    logic [11:0] rd_level_reg;
    logic [11:0] rd_level_next;
    logic        rd_empty_reg;
    logic        almost_empty_reg;
    logic [31:0] rd_data_reg;
    logic        rd_accept;

    assign wr_accept   = wr_en && !wr_full_reg;
    assign wr_ptr_next = wr_ptr_reg + {8'd0, wr_accept};

    // Upper 9 bits of a Gray code are the Gray code of ptr>>3, so only the
    // word-granular part of the read pointer needs to cross into this domain.
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_rd_g2b
            assign rd_word_ptr_sync[gi] = ^rd_gray_sync2_reg[8:gi];
        end
    endgenerate

    assign wr_level_next = wr_ptr_next - rd_word_ptr_sync;

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wr_ptr_reg        <= '0;
            wr_gray_reg       <= '0;
            rd_gray_sync1_reg <= '0;
            rd_gray_sync2_reg <= '0;
            wr_level_reg      <= '0;
            wr_full_reg       <= 1'b0;
            almost_full_reg   <= 1'b0;
        end else begin
            wr_ptr_reg        <= wr_ptr_next;
            wr_gray_reg       <= wr_ptr_next ^ (wr_ptr_next >> 1);
            rd_gray_sync1_reg <= rd_gray_reg[11:3];
            rd_gray_sync2_reg <= rd_gray_sync1_reg;
            wr_level_reg      <= wr_level_next;
            wr_full_reg       <= (wr_level_next == WR_FULL_LEVEL);
            almost_full_reg   <= (wr_level_next >= WR_ALMOST_FULL);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[7:0]] <= wr_data;
        end
    end

    assign rd_accept   = rd_en && !rd_empty_reg;
    assign rd_ptr_next = rd_ptr_reg + {11'd0, rd_accept};

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_wr_g2b
            assign wr_ptr_sync[gi] = ^wr_gray_sync2_reg[8:gi];
        end
    endgenerate

    assign rd_level_next = {wr_ptr_sync, 3'b000} - rd_ptr_next;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_ptr_reg        <= '0;
            rd_gray_reg       <= '0;
            wr_gray_sync1_reg <= '0;
            wr_gray_sync2_reg <= '0;
            rd_level_reg      <= '0;
            rd_empty_reg      <= 1'b1;
            almost_empty_reg  <= 1'b1;
        end else begin
            rd_ptr_reg        <= rd_ptr_next;
            rd_gray_reg       <= rd_ptr_next ^ (rd_ptr_next >> 1);
            wr_gray_sync1_reg <= wr_gray_reg;
            wr_gray_sync2_reg <= wr_gray_sync1_reg;
            rd_level_reg      <= rd_level_next;
            rd_empty_reg      <= (rd_level_next == 12'd0);
            almost_empty_reg  <= (rd_level_next <= RD_ALMOST_EMPTY);
        end
    end

    // Slice select comes straight from the low read-pointer bits.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data_reg <= '0;
        end else if (rd_accept) begin
            rd_data_reg <= mem[rd_ptr_reg[10:3]][{rd_ptr_reg[2:0], 5'b00000} +: 32];
        end
    end

    assign wr_full        = wr_full_reg;
    assign wr_water_level = wr_level_reg;
    assign almost_full    = almost_full_reg;
    assign rd_data        = rd_data_reg;
    assign rd_empty       = rd_empty_reg;
    assign rd_water_level = rd_level_reg;
    assign almost_empty   = almost_empty_reg;

endmodule

// File: tb/tb_read_ddr_fifo.sv
// Scoreboard bench for read_ddr_fifo: expected 32-bit slices queued at write time,
// popped by a monitor one cycle after each accepted read; levels checked against word/slice counters.
module tb_read_ddr_fifo;

    logic         clk = 1'b0;
    logic         tb_rst = 1'b1;
    logic [255:0] wr_data = '0;
    logic         wr_en = 1'b0;
    logic         wr_full;
    logic [8:0]   wr_water_level;
    logic         almost_full;
    logic [31:0]  rd_data;
    logic         rd_en = 1'b0;
    logic         rd_empty;
    logic [11:0]  rd_water_level;
    logic         almost_empty;

    always #5 clk = ~clk;

    read_ddr_fifo dut (
        .wr_clk         (clk),
        .wr_rst         (tb_rst),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .wr_full        (wr_full),
        .wr_water_level (wr_water_level),
        .almost_full    (almost_full),
        .rd_clk         (clk),
        .rd_rst         (tb_rst),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_empty       (rd_empty),
        .rd_water_level (rd_water_level),
        .almost_empty   (almost_empty)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    int          total_w = 0;   // 256-bit words accepted since reset
    int          total_r = 0;   // 32-bit slices accepted since reset
    logic [31:0] last_exp = '0;
    logic        pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int wr_lvl();
        return total_w - total_r / 8;
    endfunction

    function automatic int rd_lvl();
        return 8 * total_w - total_r;
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int k = 0; k < 8; k++) w[32*k +: 32] = $urandom();
        return w;
    endfunction

    task automatic push_word(input logic [255:0] d);
        for (int k = 0; k < 8; k++) exp_q.push_back(d[32*k +: 32]);
        total_w++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_levels(input string tag);
        chk({tag, " wr_water_level"}, 32'(wr_water_level), 32'(wr_lvl()));
        chk({tag, " wr_full"},        32'(wr_full),        32'(wr_lvl() == 256));
        chk({tag, " almost_full"},    32'(almost_full),    32'(wr_lvl() >= 252));
        chk({tag, " rd_water_level"}, 32'(rd_water_level), 32'(rd_lvl()));
        chk({tag, " rd_empty"},       32'(rd_empty),       32'(rd_lvl() == 0));
        chk({tag, " almost_empty"},   32'(almost_empty),   32'(rd_lvl() <= 4));
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs must clear before any clock edge.
    task automatic reset_pulse();
        @(posedge clk);
        #3 tb_rst = 1'b1;
        #1;
        chk("async wr_water_level", 32'(wr_water_level), 32'd0);
        chk("async rd_water_level", 32'(rd_water_level), 32'd0);
        chk("async rd_empty",       32'(rd_empty),       32'd1);
        #20;
        exp_q.delete();
        total_w = 0;
        total_r = 0;
        @(negedge clk) tb_rst = 1'b0;
        step();
    endtask

    // Monitor: a read accepted before edge N produces its slice after edge N.
    always @(negedge clk) begin
        if (tb_rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL rd_data: got %0h, expected no data (scoreboard empty)", rd_data);
                end else begin
                    last_exp = exp_q.pop_front();
                    chk("rd_data", rd_data, last_exp);
                end
            end
            pending = rd_en && !rd_empty;
        end
    end

    initial begin
        logic [255:0] d;
        logic         acc;

        // Reset state
        #200;
        chk("reset wr_full",        32'(wr_full),        32'd0);
        chk("reset wr_water_level", 32'(wr_water_level), 32'd0);
        chk("reset almost_full",    32'(almost_full),    32'd0);
        chk("reset rd_empty",       32'(rd_empty),       32'd1);
        chk("reset rd_water_level", 32'(rd_water_level), 32'd0);
        chk("reset almost_empty",   32'(almost_empty),   32'd1);
        chk("reset rd_data",        rd_data,             32'd0);
        @(negedge clk) tb_rst = 1'b0;
        step();
        $display("[TB] reset checked");

        // Fill with descending data from all-ones; 257th write must be dropped
        for (int i = 0; i < 257; i++) begin
            d = '1;
            d = d - 256'(i);
            wr_data = d;
            wr_en = 1'b1;
            acc = (wr_lvl() < 256);
            if (acc) push_word(d);
            step();
            chk("fill wr_water_level", 32'(wr_water_level), 32'(wr_lvl()));
            chk("fill almost_full",    32'(almost_full),    32'(wr_lvl() >= 252));
            chk("fill wr_full",        32'(wr_full),        32'(wr_lvl() == 256));
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_levels("filled");
        $display("[TB] fill done, %0d words", total_w);

        // Drain all 2048 slices plus one ignored read
        for (int i = 0; i < 2049; i++) begin
            rd_en = 1'b1;
            if (rd_lvl() > 0) total_r++;
            step();
            chk("drain rd_water_level", 32'(rd_water_level), 32'(rd_lvl()));
            chk("drain rd_empty",       32'(rd_empty),       32'(rd_lvl() == 0));
            chk("drain almost_empty",   32'(almost_empty),   32'(rd_lvl() <= 4));
        end
        rd_en = 1'b0;
        chk("ignored read holds rd_data", rd_data, last_exp);
        for (int i = 0; i < 6; i++) step();
        check_levels("drained");
        $display("[TB] drain done, %0d slices", total_r);

        // Half level, then random concurrent traffic kept clear of both flags
        for (int i = 0; i < 128; i++) begin
            d = rand_word();
            wr_data = d;
            wr_en = 1'b1;
            push_word(d);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_levels("half");
        for (int i = 0; i < 400; i++) begin
            wr_en = ($urandom_range(0, 15) == 0) && (wr_lvl() < 200);
            if (wr_en) begin
                d = rand_word();
                wr_data = d;
                push_word(d);
            end
            rd_en = ($urandom_range(0, 1) == 1) && (rd_lvl() > 64);
            if (rd_en) total_r++;
            step();
            chk("concurrent wr_full",  32'(wr_full),  32'd0);
            chk("concurrent rd_empty", 32'(rd_empty), 32'd0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_levels("concurrent");
        $display("[TB] concurrent done, wr level %0d rd level %0d", wr_lvl(), rd_lvl());

        // Reset after 100 writes discards everything
        reset_pulse();
        for (int i = 0; i < 100; i++) begin
            d = rand_word();
            wr_data = d;
            wr_en = 1'b1;
            push_word(d);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset_pulse();
        for (int i = 0; i < 6; i++) step();
        check_levels("post reset");
        $display("[TB] mid-operation reset done");

        // FIFO still works after the reset
        for (int i = 0; i < 2; i++) begin
            d = rand_word();
            wr_data = d;
            wr_en = 1'b1;
            push_word(d);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_levels("refill");
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            total_r++;
            step();
        end
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_levels("final");
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/read_ddr_fifo.md
READ_DDR_FIFO -- requirements
Module: read_ddr_fifo

Interface
REQ-001 Reset tb_rst, asynchronous, active-high; clock clk. tb_rst drives both wr_rst and rd_rst; clk drives both wr_clk and rd_clk. The design SHALL still be fully asynchronous between the two domains.
REQ-002 wr_clk  input  1  write-domain clock, rising edge.
REQ-003 wr_rst  input  1  write-domain reset, asynchronous, active-high.
REQ-004 rd_clk  input  1  read-domain clock, rising edge, non-inverted.
REQ-005 rd_rst  input  1  read-domain reset, asynchronous, active-high.
REQ-006 wr_data  input  256  write word.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_full  output  1  FIFO full, write domain.
REQ-009 wr_water_level  output  9  stored 256-bit words, range 0..256.
REQ-010 almost_full  output  1  set when wr_water_level >= 252.
REQ-011 rd_data  output  32  read data.
REQ-012 rd_en  input  1  read request.
REQ-013 rd_empty  output  1  FIFO empty, read domain.
REQ-014 rd_water_level  output  12  available 32-bit words, range 0..2048.
REQ-015 almost_empty  output  1  set when rd_water_level <= 4.
REQ-016 Fixed parameters: write depth 256 x 256 bits, read depth 2048 x 32 bits, no output register, no rd_oce, no byte enables.
REQ-017 The block SHALL operate correctly alongside a GTP_GRS instance with GRS_N tied to 1, which has no functional effect.

Function
REQ-018 A write is accepted when wr_en=1 and wr_full=0 at a wr_clk edge: the word is stored and the 9-bit binary write pointer increments. A write attempted while full SHALL be ignored with no state change.
REQ-019 Each 256-bit word SHALL be read as eight 32-bit words, least-significant slice first: [31:0], then [63:32], and so on up to [255:224].
REQ-020 A read is accepted when rd_en=1 and rd_empty=0 at an rd_clk edge. The 12-bit read pointer increments, and rd_data SHALL present the addressed 32-bit slice from the next rd_clk edge, giving 1-cycle latency.
REQ-021 A read attempted while empty SHALL be ignored; the pointer and rd_data hold their values.
REQ-022 Pointers SHALL cross domains as Gray code through 2-flop synchronizers in the destination domain.
REQ-023 Write-domain occupancy SHALL be computed as wr_ptr - (synchronized rd_ptr >> 3), modulo 512. A partially read word counts as occupied.
REQ-024 Read-domain occupancy SHALL be computed as (synchronized wr_ptr << 3) - rd_ptr, modulo 4096.
REQ-025 wr_full, wr_water_level and almost_full SHALL be registered and include the current accepted write. wr_full rises on the same edge that stores the 256th word.
REQ-026 rd_empty, rd_water_level and almost_empty SHALL be registered and include the current accepted read. rd_empty rises on the edge that consumes the last 32-bit word.
REQ-027 Flags SHALL be pessimistic: full and empty deassert only after the pointer-synchronizer delay of 2-3 destination clocks.
REQ-028 Pointers SHALL wrap naturally, with the extra MSB distinguishing full from empty.
REQ-029 Simultaneous read and write SHALL both be honoured when their respective flags allow.

Reset
REQ-030 Asserting wr_rst SHALL clear, asynchronously: the write pointer, its Gray copy, the read-pointer synchronizers, wr_water_level (0), wr_full (0) and almost_full (0).
REQ-031 Asserting rd_rst SHALL clear, asynchronously: the read pointer, its Gray copy, the write-pointer synchronizers, rd_water_level (0), rd_data (0), rd_empty (1) and almost_empty (1).
REQ-032 Reset asserted mid-operation SHALL discard all contents, and the FIFO SHALL be empty after release. Memory contents need not be cleared.

Verification
REQ-033 Reset check: hold tb_rst for 200 ns -> wr_full=0, wr_water_level=0, almost_full=0, rd_empty=1, rd_water_level=0, almost_empty=1.
REQ-034 Fill: issue 257 consecutive writes with descending data starting at all-ones -> almost_full set from level 252; wr_full=1 after the 256th write; the 257th write is ignored; wr_water_level=256.
REQ-035 Read-domain level: after the fill and synchronizer settling -> rd_water_level=2048, rd_empty=0, almost_empty=0.
REQ-036 Drain: issue 2049 consecutive reads ->
- data appears 1 cycle after each rd_en, LSB slice first; the first eight reads are 0xFFFFFFFF, and the ninth read is 0xFFFFFFFE;
- almost_empty sets when rd_water_level <= 4;
- rd_empty=1 after the 2048th read, and the 2049th read is ignored.
REQ-037 Simultaneous access: with the FIFO at half level, perform concurrent write and read -> levels stay consistent with no data loss.
REQ-038 Mid-operation reset: pulse tb_rst after 100 writes -> FIFO is empty and levels read 0.
